// File: rtl/gpio_loader_pkg.sv
// gpio_loader_pkg
//   Shared types and constants for the GPIO configuration chain loader.
//   - state_e           : loader FSM states
//   - CFG_WIDTH_DEFAULT : default bits per pad configuration word
//   - DIV_CNT_W         : width of the serial clock divider counter
//   - cnt_width()       : counter width for n states, never less than 1 bit
package gpio_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD,
    DONE
  } state_e;

  localparam int unsigned CFG_WIDTH_DEFAULT = 10;
  localparam int unsigned DIV_CNT_W         = 8;

  // $clog2(1) is 0; a zero-width counter is not legal, so clamp to 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_config_loader_serial_clk_phase.sv
// serial_clk_phase
//   CLK_DIV divider for the chain shift clock. While run_i is high it counts
//   CLK_DIV core cycles per half-period and flags the last cycle of each
//   half-period with a one-cycle strobe; the strobe names the edge that the
//   next core clock edge will produce on the serial clock.
//   Ports:
//     clk_i, rst_ni   : core clock, asynchronous active-low reset
//     run_i           : divider running; low clears counter and phase
//     clk_en_i        : let the phase reach serial_clock_o (low forces 0)
//     ovr_en_i        : override the serial clock with ovr_val_i
//     ovr_val_i       : override level, registered like the normal path
//     phase_rise_o    : last cycle of a low half-period
//     phase_fall_o    : last cycle of a high half-period
//     serial_clock_o  : registered serial clock level
module serial_clk_phase
  import gpio_loader_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clk_en_i,
  input  logic ovr_en_i,
  input  logic ovr_val_i,
  output logic phase_rise_o,
  output logic phase_fall_o,
  output logic serial_clock_o
);

  localparam logic [DIV_CNT_W-1:0] TC_VAL = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic                 sclk_q;
  logic                 tc;

  always_comb begin
    tc           = run_i && (cnt_q == TC_VAL);
    phase_rise_o = tc && !phase_q;
    phase_fall_o = tc && phase_q;
    cnt_d        = (!run_i || tc) ? '0 : cnt_q + 1'b1;
    phase_d      = run_i ? (phase_q ^ tc) : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      // Register the next phase so the pin edge lines up with the strobe.
      sclk_q  <= ovr_en_i ? ovr_val_i : (clk_en_i && phase_d);
    end
  end

  assign serial_clock_o = sclk_q;

endmodule

// File: rtl/gpio_config_loader.sv
// gpio_config_loader
//   Programs one GPIO control-block daisy chain. On xfer_start it reads one
//   CFG_WIDTH word per pad (pad NUM_GPIO-1 first, MSB first), shifts the bits
//   out on serial_data/serial_clock, then strobes serial_load for 2*CLK_DIV
//   cycles so all pads latch together, and pulses xfer_done.
//   Ports:
//     wb_clk_i, wb_rstn_i : core clock, asynchronous active-low reset
//     xfer_start          : request a full chain transfer (ignored when busy)
//     xfer_busy/xfer_done : transfer in progress / one-cycle completion pulse
//     cfg_rd_idx/_data    : config register file read (combinational data)
//     serial_clock/_load/_data/_resetn : chain pins, all registered
//   Optional macro GPIO_LOADER_BITBANG_EN adds bitbang_en/_clock/_load/_data
//   inputs that drive the serial pins directly while the loader is idle.
module gpio_config_loader
  import gpio_loader_pkg::*;
#(
  parameter  int unsigned NUM_GPIO  = 19,
  parameter  int unsigned CFG_WIDTH = CFG_WIDTH_DEFAULT,
  parameter  int unsigned CLK_DIV   = 4,   // legal range 1..255
  localparam int unsigned IDX_W     = cnt_width(NUM_GPIO),
  localparam int unsigned BIT_W     = cnt_width(CFG_WIDTH)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rstn_i,
  input  logic                 xfer_start,
  output logic                 xfer_busy,
  output logic                 xfer_done,
  output logic [IDX_W-1:0]     cfg_rd_idx,
  input  logic [CFG_WIDTH-1:0] cfg_rd_data,
  output logic                 serial_clock,
  output logic                 serial_load,
  output logic                 serial_data,
  output logic                 serial_resetn
`ifdef GPIO_LOADER_BITBANG_EN
  ,
  input  logic                 bitbang_en,
  input  logic                 bitbang_clock,
  input  logic                 bitbang_load,
  input  logic                 bitbang_data
`endif
);

  localparam logic [IDX_W-1:0] LAST_PAD = IDX_W'(NUM_GPIO - 1);
  localparam logic [BIT_W-1:0] MSB_BIT  = BIT_W'(CFG_WIDTH - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             last_q;
  logic             busy_q, done_q, load_q, data_q, rstn_q;
  logic             phase_rise, phase_fall, sclk;
  logic             bb_active, bb_clock, bb_load, bb_data;

`ifdef GPIO_LOADER_BITBANG_EN
  assign bb_active = (state_q == IDLE) && bitbang_en;
  assign bb_clock  = bitbang_clock;
  assign bb_load   = bitbang_load;
  assign bb_data   = bitbang_data;
`else
  assign bb_active = 1'b0;
  assign bb_clock  = 1'b0;
  assign bb_load   = 1'b0;
  assign bb_data   = 1'b0;
`endif

  // Pad counter saturates at 0; bit counter wraps 0 -> CFG_WIDTH-1.
  always_comb begin
    idx_d = (idx_q == '0) ? '0 : idx_q - 1'b1;
    bit_d = (bit_q == '0) ? MSB_BIT : bit_q - 1'b1;
  end

  serial_clk_phase #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_phase (
    .clk_i         (wb_clk_i),
    .rst_ni        (wb_rstn_i),
    .run_i         ((state_q == SHIFT) || (state_q == LOAD)),
    .clk_en_i      (state_q == SHIFT),
    .ovr_en_i      (bb_active),
    .ovr_val_i     (bb_clock),
    .phase_rise_o  (phase_rise),
    .phase_fall_o  (phase_fall),
    .serial_clock_o(sclk)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      idx_q   <= LAST_PAD;
      bit_q   <= MSB_BIT;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      data_q  <= 1'b0;
      rstn_q  <= 1'b0;
    end else begin
      rstn_q <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          load_q <= bb_active && bb_load;
          data_q <= bb_active && bb_data;
          if (!bb_active && xfer_start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            bit_q   <= MSB_BIT;
            last_q  <= 1'b0;
            data_q  <= cfg_rd_data[CFG_WIDTH-1];
          end
        end
        SHIFT: begin
          // Step to the next pad once bit 0 has been clocked into the chain,
          // so cfg_rd_data already holds the next word at the following fall.
          if (phase_rise && (bit_q == '0)) begin
            idx_q  <= idx_d;
            last_q <= (idx_q == '0);
          end
          if (phase_fall) begin
            bit_q <= bit_d;
            if ((bit_q == '0) && last_q) begin
              state_q <= LOAD;
              load_q  <= 1'b1;
              data_q  <= 1'b0;
              idx_q   <= LAST_PAD;
              last_q  <= 1'b0;
            end else begin
              data_q <= cfg_rd_data[bit_d];
            end
          end
        end
        LOAD: begin
          // The divider keeps running; one full period gives 2*CLK_DIV cycles.
          if (phase_fall) begin
            state_q <= DONE;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign xfer_busy     = busy_q;
  assign xfer_done     = done_q;
  assign cfg_rd_idx    = idx_q;
  assign serial_clock  = sclk;
  assign serial_load   = load_q;
  assign serial_data   = data_q;
  assign serial_resetn = rstn_q;

endmodule

// File: tb/tb_gpio_config_loader.sv
// tb_gpio_config_loader
//   Directed bench for gpio_config_loader with NUM_GPIO=3, CFG_WIDTH=10,
//   CLK_DIV=2. The bench acts as the config register file and models the
//   chain as a shift register clocked by serial_clock.
module tb_gpio_config_loader;

  localparam int NG    = 3;
  localparam int CW    = 10;
  localparam int CD    = 2;
  localparam int NBITS = NG * CW;
  localparam logic [NBITS-1:0] EXP_STREAM = {10'h3FF, 10'h000, 10'h2A5};
  localparam int EXP_LAT = 1 + 2 * CD * (NBITS + 1);   // 125

  logic          wb_clk_i   = 1'b0;
  logic          wb_rstn_i  = 1'b0;
  logic          xfer_start = 1'b0;
  logic          xfer_busy, xfer_done;
  logic [1:0]    cfg_rd_idx;
  logic [CW-1:0] cfg_rd_data;
  logic          serial_clock, serial_load, serial_data, serial_resetn;
`ifdef GPIO_LOADER_BITBANG_EN
  logic          bitbang_en    = 1'b0;
  logic          bitbang_clock = 1'b0;
  logic          bitbang_load  = 1'b0;
  logic          bitbang_data  = 1'b0;
`endif

  logic [CW-1:0] cfg_mem [NG];
  assign cfg_rd_data = cfg_mem[cfg_rd_idx];

  gpio_config_loader #(
    .NUM_GPIO (NG),
    .CFG_WIDTH(CW),
    .CLK_DIV  (CD)
  ) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rstn_i    (wb_rstn_i),
    .xfer_start   (xfer_start),
    .xfer_busy    (xfer_busy),
    .xfer_done    (xfer_done),
    .cfg_rd_idx   (cfg_rd_idx),
    .cfg_rd_data  (cfg_rd_data),
    .serial_clock (serial_clock),
    .serial_load  (serial_load),
    .serial_data  (serial_data),
    .serial_resetn(serial_resetn)
`ifdef GPIO_LOADER_BITBANG_EN
    ,
    .bitbang_en   (bitbang_en),
    .bitbang_clock(bitbang_clock),
    .bitbang_load (bitbang_load),
    .bitbang_data (bitbang_data)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Chain model: every serial_clock rising edge shifts one bit in.
  logic [NBITS-1:0] chain_q    = '0;
  int unsigned      sclk_rises = 0;
  always @(posedge serial_clock) begin
    chain_q    <= {chain_q[NBITS-2:0], serial_data};
    sclk_rises <= sclk_rises + 1;
  end

  // Cycle monitor: load/done counts and serial_data stability around edges.
  int unsigned load_cycles = 0;
  int unsigned done_pulses = 0;
  int unsigned setup_viol  = 0;
  int          since_chg   = 99;
  int          since_rise  = 99;
  logic        prev_data   = 1'b0;
  logic        prev_sclk   = 1'b0;
  bit          mon_en      = 1'b0;
  always @(negedge wb_clk_i) begin
    if (serial_load) load_cycles <= load_cycles + 1;
    if (xfer_done)   done_pulses <= done_pulses + 1;
    if (mon_en) begin
      if (serial_clock && !prev_sclk && (since_chg < 1 || serial_data != prev_data))
        setup_viol <= setup_viol + 1;
      else if (serial_data != prev_data && since_rise < 1)
        setup_viol <= setup_viol + 1;
    end
    since_chg  <= (serial_data != prev_data) ? 0 : since_chg + 1;
    since_rise <= (serial_clock && !prev_sclk) ? 0 : since_rise + 1;
    prev_data  <= serial_data;
    prev_sclk  <= serial_clock;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=0x%0h", tag, got);
    end
  endtask

  // Pulse xfer_start for one cycle and count core cycles until xfer_done.
  task automatic start_and_wait(output int lat);
    lat = 0;
    @(negedge wb_clk_i) xfer_start = 1'b1;
    @(negedge wb_clk_i) xfer_start = 1'b0;
    lat = 1;
    while (!xfer_done && lat < 1000) begin
      @(negedge wb_clk_i);
      lat++;
    end
  endtask

  int          lat;
  int          n;
  int unsigned r0, l0, d0;
  logic [2:0]  bb_seq;

  initial begin
    cfg_mem[2] = 10'h3FF;
    cfg_mem[1] = 10'h000;
    cfg_mem[0] = 10'h2A5;

    // ---- reset and idle ----
    wb_rstn_i = 1'b0;
    repeat (5) @(posedge wb_clk_i);
    #1;
    check_eq("rst_busy",   64'(xfer_busy),     64'(0));
    check_eq("rst_done",   64'(xfer_done),     64'(0));
    check_eq("rst_sclk",   64'(serial_clock),  64'(0));
    check_eq("rst_load",   64'(serial_load),   64'(0));
    check_eq("rst_data",   64'(serial_data),   64'(0));
    check_eq("rst_resetn", 64'(serial_resetn), 64'(0));
    check_eq("rst_idx",    64'(cfg_rd_idx),    64'(NG - 1));
    @(negedge wb_clk_i) wb_rstn_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    check_eq("resetn_after_release", 64'(serial_resetn), 64'(1));
    repeat (10) @(negedge wb_clk_i);
    check_eq("idle_no_sclk_edges", 64'(sclk_rises), 64'(0));
    check_eq("idle_busy",          64'(xfer_busy),  64'(0));

    // ---- basic transfer ----
    r0 = sclk_rises; l0 = load_cycles; d0 = done_pulses;
    mon_en = 1'b1;
    @(negedge wb_clk_i) xfer_start = 1'b1;
    @(negedge wb_clk_i) xfer_start = 1'b0;
    check_eq("basic_busy_rise", 64'(xfer_busy), 64'(1));
    lat = 1;
    while (!xfer_done && lat < 1000) begin
      @(negedge wb_clk_i);
      lat++;
    end
    check_eq("basic_latency",    64'(lat),                    64'(EXP_LAT));
    check_eq("basic_bits",       64'(sclk_rises - r0),        64'(NBITS));
    check_eq("basic_stream",     64'(chain_q),                64'(EXP_STREAM));
    check_eq("basic_load_len",   64'(load_cycles - l0),       64'(2 * CD));
    check_eq("basic_busy_done",  64'(xfer_busy),              64'(0));
    check_eq("basic_setup_hold", 64'(setup_viol),             64'(0));
    @(negedge wb_clk_i);
    mon_en = 1'b0;
    check_eq("basic_done_pulse", 64'(done_pulses - d0),       64'(1));
    check_eq("basic_done_low",   64'(xfer_done),              64'(0));
    check_eq("basic_idx_home",   64'(cfg_rd_idx),             64'(NG - 1));

    // ---- start while busy / in DONE ----
    r0 = sclk_rises; d0 = done_pulses;
    @(negedge wb_clk_i) xfer_start = 1'b1;
    @(negedge wb_clk_i) xfer_start = 1'b0;
    repeat (9) @(negedge wb_clk_i);
    xfer_start = 1'b1;
    @(negedge wb_clk_i) xfer_start = 1'b0;
    n = 0;
    while (!xfer_done && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    xfer_start = 1'b1;                      // during the DONE cycle
    @(negedge wb_clk_i) xfer_start = 1'b0;
    repeat (200) @(negedge wb_clk_i);
    check_eq("busy_start_done_cnt", 64'(done_pulses - d0), 64'(1));
    check_eq("busy_start_bits",     64'(sclk_rises - r0),  64'(NBITS));
    check_eq("busy_start_idle",     64'(xfer_busy),        64'(0));

    // ---- xfer_start held for three cycles ----
    d0 = done_pulses;
    @(negedge wb_clk_i) xfer_start = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    xfer_start = 1'b0;
    n = 0;
    while (!xfer_done && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    repeat (20) @(negedge wb_clk_i);
    check_eq("held_start_done_cnt", 64'(done_pulses - d0), 64'(1));

    // ---- reset in the middle of a transfer ----
    r0 = sclk_rises;
    @(negedge wb_clk_i) xfer_start = 1'b1;
    @(negedge wb_clk_i) xfer_start = 1'b0;
    n = 0;
    while ((sclk_rises - r0) < 17 && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    check_eq("mid_reached_bit17", 64'(sclk_rises - r0), 64'(17));
    check_eq("mid_sclk_before",   64'(serial_clock),     64'(1));
    check_eq("mid_busy_before",   64'(xfer_busy),        64'(1));
    #2 wb_rstn_i = 1'b0;
    #1;
    check_eq("mid_rst_sclk",   64'(serial_clock),  64'(0));
    check_eq("mid_rst_data",   64'(serial_data),   64'(0));
    check_eq("mid_rst_load",   64'(serial_load),   64'(0));
    check_eq("mid_rst_busy",   64'(xfer_busy),     64'(0));
    check_eq("mid_rst_resetn", 64'(serial_resetn), 64'(0));
    check_eq("mid_rst_idx",    64'(cfg_rd_idx),    64'(NG - 1));
    repeat (3) @(negedge wb_clk_i);
    wb_rstn_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    r0 = sclk_rises;
    start_and_wait(lat);
    check_eq("restart_latency", 64'(lat),              64'(EXP_LAT));
    check_eq("restart_bits",    64'(sclk_rises - r0),  64'(NBITS));
    check_eq("restart_stream",  64'(chain_q),          64'(EXP_STREAM));

`ifdef GPIO_LOADER_BITBANG_EN
    // ---- bit-bang pass-through ----
    repeat (2) @(negedge wb_clk_i);
    bitbang_en = 1'b1;
    bb_seq = 3'b101;
    for (int i = 0; i < 3; i++) begin
      bitbang_clock = 1'b0;
      bitbang_data  = bb_seq[2-i];
      @(negedge wb_clk_i);
      check_eq($sformatf("bb_low_sclk_%0d", i), 64'(serial_clock), 64'(0));
      check_eq($sformatf("bb_data_%0d", i),     64'(serial_data),  64'(bb_seq[2-i]));
      bitbang_clock = 1'b1;
      @(negedge wb_clk_i);
      check_eq($sformatf("bb_high_sclk_%0d", i), 64'(serial_clock), 64'(1));
    end
    bitbang_clock = 1'b0;
    bitbang_load  = 1'b1;
    xfer_start    = 1'b1;
    @(negedge wb_clk_i);
    xfer_start    = 1'b0;
    check_eq("bb_load", 64'(serial_load), 64'(1));
    bitbang_load = 1'b0;
    bitbang_data = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check_eq("bb_start_ignored", 64'(xfer_busy), 64'(0));
    bitbang_en = 1'b0;
    @(negedge wb_clk_i);
    r0 = sclk_rises;
    start_and_wait(lat);
    check_eq("bb_off_latency", 64'(lat),             64'(EXP_LAT));
    check_eq("bb_off_bits",    64'(sclk_rises - r0), 64'(NBITS));
    check_eq("bb_off_stream",  64'(chain_q),         64'(EXP_STREAM));
`endif

    repeat (5) @(negedge wb_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
